pb_axi_err_responder: RTL
=========================

// Module: pb_axi_err_responder
// PURPOSE
// AXI4 subordinate that terminates every transaction it receives with an error response.
// Sits behind the NoC chimney of unpopulated mesh positions and decode holes. Stray AW/W/AR
// traffic from cluster, Cheshire or mem tiles then completes with DECERR instead of hanging the mesh.
// Queues up to MaxTxns outstanding writes and reads independently; bursts are fully drained/returned.
// PARAMETERS
// IdWidth    4             AXI ID width on all channels
// DataWidth  64            R data width; multiple of 32
// MaxTxns    4             depth of AW-ID and AR-ID/len queues (>=1, power of two)
// RespCode   2'b11         xRESP returned on every B and R beat (DECERR)
// RespData   32'hBADCAB1E  pattern replicated DataWidth/32 times on r_data_o
// PORTS
// clk_i        in   1          clock
// rst_ni       in   1          async active-low reset
// aw_valid_i   in   1          write address valid
// aw_ready_o   out  1          write address ready
// aw_id_i      in   IdWidth    write ID
// w_valid_i    in   1          write data valid (data/strb ignored, not ported)
// w_ready_o    out  1          write data ready
// w_last_i     in   1          last write beat of burst
// b_valid_o    out  1          write response valid
// b_ready_i    in   1          write response ready
// b_id_o       out  IdWidth    write response ID
// b_resp_o     out  2          write response code
// ar_valid_i   in   1          read address valid
// ar_ready_o   out  1          read address ready
// ar_id_i      in   IdWidth    read ID
// ar_len_i     in   8          read burst length minus one
// r_valid_o    out  1          read data valid
// r_ready_i    in   1          read data ready
// r_id_o       out  IdWidth    read ID
// r_data_o     out  DataWidth  RespData replicated
// r_resp_o     out  2          RespCode
// r_last_o     out  1          last read beat
// BEHAVIOUR
// - Reset: queues empty, FSMs IDLE, beat counter 0. aw_ready_o=ar_ready_o=1 once reset released.
//   w_ready_o=b_valid_o=r_valid_o=r_last_o=0; b_id_o/r_id_o/r_data_o don't-care while valid low.
// - aw_ready_o = !aw_q_full; ar_ready_o = !ar_q_full. No pass-through when full; push on full impossible.
//   Simultaneous push+pop on a non-full queue is legal and keeps the count unchanged.
// - Write FSM:
//   W_IDLE  -> W_DRAIN when aw_q non-empty.
//   W_DRAIN: w_ready_o=1; accept beats; on w_valid_i&w_last_i -> W_RESP.
//   W_RESP: b_valid_o=1, b_id_o=aw_q head, b_resp_o=RespCode; on b_ready_i pop aw_q -> W_IDLE.
//   aw_len ignored; burst end by w_last_i only. W beats before their AW stall (w_ready_o=0).
//   Latency: AW handshake cycle t -> w_ready_o at t+2 earliest; B valid cycle after last-W handshake.
// - Read FSM:
//   R_IDLE  -> R_SEND when ar_q non-empty; load cnt=head len.
//   R_SEND: r_valid_o=1, r_id_o=head id, r_last_o=(cnt==0); each r handshake cnt--.
//   On last handshake pop ar_q -> R_IDLE. AR at t -> first R beat at t+2 earliest.
//   cnt 8 bits, never wraps: len=0 gives 1 beat with r_last_o=1; len=255 gives 256 beats.
// - AXI stability: all R/B payloads constant while valid&!ready; valid never drops without handshake.
// - Write and read paths fully independent; responses per direction in acceptance order (IDs not reordered).
// - Async reset mid-burst: queues flushed, FSMs IDLE, valids low immediately; in-flight txns lost.
// TESTING
// 1 AW id=3, W 4 beats last on 4th, b_ready=1 -> one B id=3 resp=2'b11, exactly 1 cycle after last W.
// 2 AR id=5 len=0 -> one R beat id=5, data=64'hBADCAB1E_BADCAB1E, resp=11, last=1.
// 3 AR id=1 len=255, r_ready toggling 50% -> 256 beats, last only on 256th, payload stable on stalls.
// 4 5 ARs back-to-back, r_ready=0 -> ar_ready_o low after 4th; 5th accepted after 1st burst done; IDs in order.
// 5 W beats issued 10 cycles before AW -> w_ready_o stays 0 until AW queued; then single B.
// 6 Assert rst_ni low mid 8-beat read -> r_valid_o=0 same cycle; after release ar_ready_o=1, no stale R.

Source files
------------

// File: rtl/pb_axi_err_responder.sv
// AXI4 error subordinate: completes every write and read burst with RespCode.
// Write and read paths are independent, each with its own in-order request queue.
module pb_axi_err_responder #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxTxns   = 4,
  parameter logic [1:0]  RespCode  = 2'b11,
  parameter logic [31:0] RespData  = 32'hBADCAB1E
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
);

  localparam int unsigned PtrW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
  localparam int unsigned CntW = $clog2(MaxTxns + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTxns - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(MaxTxns);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DRAIN,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } r_state_e;

  // Explicit wrap keeps the pointers correct for any depth, including 1
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // ---------------- AW-ID queue ----------------
  logic [IdWidth-1:0] aw_q_id [MaxTxns];
  logic [PtrW-1:0]    aw_wr_ptr, aw_rd_ptr;
  logic [CntW-1:0]    aw_cnt;
  logic               aw_full, aw_empty, aw_push, aw_pop;

  assign aw_full    = (aw_cnt == FullCnt);
  assign aw_empty   = (aw_cnt == '0);
  assign aw_ready_o = !aw_full;
  assign aw_push    = aw_valid_i && !aw_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_wr_ptr <= '0;
      aw_rd_ptr <= '0;
      aw_cnt    <= '0;
    end else begin
      if (aw_push) aw_wr_ptr <= ptr_inc(aw_wr_ptr);
      if (aw_pop)  aw_rd_ptr <= ptr_inc(aw_rd_ptr);
      case ({aw_push, aw_pop})
        2'b10:   aw_cnt <= aw_cnt + CntW'(1);
        2'b01:   aw_cnt <= aw_cnt - CntW'(1);
        default: aw_cnt <= aw_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_push) aw_q_id[aw_wr_ptr] <= aw_id_i;
  end

  // ---------------- AR-ID/len queue ----------------
  logic [IdWidth-1:0] ar_q_id  [MaxTxns];
  logic [7:0]         ar_q_len [MaxTxns];
  logic [PtrW-1:0]    ar_wr_ptr, ar_rd_ptr;
  logic [CntW-1:0]    ar_cnt;
  logic               ar_full, ar_empty, ar_push, ar_pop;

  assign ar_full    = (ar_cnt == FullCnt);
  assign ar_empty   = (ar_cnt == '0);
  assign ar_ready_o = !ar_full;
  assign ar_push    = ar_valid_i && !ar_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ar_wr_ptr <= '0;
      ar_rd_ptr <= '0;
      ar_cnt    <= '0;
    end else begin
      if (ar_push) ar_wr_ptr <= ptr_inc(ar_wr_ptr);
      if (ar_pop)  ar_rd_ptr <= ptr_inc(ar_rd_ptr);
      case ({ar_push, ar_pop})
        2'b10:   ar_cnt <= ar_cnt + CntW'(1);
        2'b01:   ar_cnt <= ar_cnt - CntW'(1);
        default: ar_cnt <= ar_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ar_push) begin
      ar_q_id[ar_wr_ptr]  <= ar_id_i;
      ar_q_len[ar_wr_ptr] <= ar_len_i;
    end
  end

  // ---------------- Write FSM ----------------
  w_state_e w_state_q, w_state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) w_state_q <= W_IDLE;
    else         w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    w_ready_o = 1'b0;
    b_valid_o = 1'b0;
    aw_pop    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (!aw_empty) w_state_d = W_DRAIN;
      end
      W_DRAIN: begin
        w_ready_o = 1'b1;
        if (w_valid_i && w_last_i) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_o = 1'b1;
        if (b_ready_i) begin
          aw_pop    = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Queue head only moves on pop, so the B payload is stable while stalled
  assign b_id_o   = aw_q_id[aw_rd_ptr];
  assign b_resp_o = RespCode;

  // ---------------- Read FSM ----------------
  r_state_e   r_state_q, r_state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= R_IDLE;
      beat_cnt_q <= '0;
    end else begin
      r_state_q  <= r_state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    r_state_d  = r_state_q;
    beat_cnt_d = beat_cnt_q;
    r_valid_o  = 1'b0;
    r_last_o   = 1'b0;
    ar_pop     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!ar_empty) begin
          beat_cnt_d = ar_q_len[ar_rd_ptr];
          r_state_d  = R_SEND;
        end
      end
      R_SEND: begin
        r_valid_o = 1'b1;
        r_last_o  = (beat_cnt_q == '0);
        if (r_ready_i) begin
          if (beat_cnt_q == '0) begin
            ar_pop    = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign r_id_o   = ar_q_id[ar_rd_ptr];
  assign r_data_o = {(DataWidth / 32){RespData}};
  assign r_resp_o = RespCode;

endmodule
